// File: rtl/bitcoin_pkg.sv
// Shared definitions for the bitcoin hash core and the nonce sweep controller:
// sweep FSM state encoding, default lanes per core run, and the SHA-256
// initial hash values and round constants used by the core.
package bitcoin_pkg;

  // Lanes hashed in parallel by one core run.
  localparam int NUM_NONCES_DEFAULT = 16;

  // Sweep controller state codes (kept as plain constants for older tools).
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_READ   = 3'd3;
  localparam logic [2:0] S_NEXT   = 3'd4;
  localparam logic [2:0] S_DRAIN  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE   = S_IDLE,
    ST_LAUNCH = S_LAUNCH,
    ST_WAIT   = S_WAIT,
    ST_READ   = S_READ,
    ST_NEXT   = S_NEXT,
    ST_DRAIN  = S_DRAIN,
    ST_DONE   = S_DONE
  } sweep_state_e;

  // SHA-256 initial hash value H0..H7.
  localparam logic [31:0] SHA256_IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  // SHA-256 round constants K0..K63.
  localparam logic [31:0] SHA256_K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

endpackage

// File: rtl/nonce_hit_tracker.sv
// Compares each returned H0 word against the difficulty target and keeps the
// sweep results: first-hit flag, winning nonce/hash and a saturating hit count.
// Samples arrive in ascending nonce order, so the first hit is the lowest lane.
module nonce_hit_tracker #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             sample_valid,
  input  logic [31:0]      lane_nonce,
  input  logic [31:0]      data,
  input  logic [31:0]      target,
  output logic             found,
  output logic [31:0]      win_nonce,
  output logic [31:0]      win_hash,
  output logic [CNT_W-1:0] hit_count
);

  logic hit;
  assign hit = sample_valid && (data < target);

  // Capture the first hit of the sweep and count every hit, saturating.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      found     <= 1'b0;
      win_nonce <= '0;
      win_hash  <= '0;
      hit_count <= '0;
    end else if (clear) begin
      found     <= 1'b0;
      win_nonce <= '0;
      win_hash  <= '0;
      hit_count <= '0;
    end else if (hit) begin
      if (!found) begin
        found     <= 1'b1;
        win_nonce <= lane_nonce;
        win_hash  <= data;
      end
      if (hit_count != {CNT_W{1'b1}}) begin
        hit_count <= hit_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/nonce_sweep_ctrl.sv
// Nonce sweep scheduler: launches one hash-core run per batch of NUM_NONCES
// nonces, then owns the memory port to read back each lane's H0 and feeds it
// to the hit tracker. Abort while the core is running waits in DRAIN for the
// core to finish so no run is left orphaned.
// Build option: NONCE_SWEEP_EARLY_EXIT_EN stops the sweep after the batch in
// which the first hit was found.
module nonce_sweep_ctrl
  import bitcoin_pkg::*;
#(
  parameter int NUM_NONCES = NUM_NONCES_DEFAULT,
  parameter int ADDR_W     = 16,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] message_addr,
  input  logic [ADDR_W-1:0] output_addr,
  input  logic [31:0]       nonce_start,
  input  logic [CNT_W-1:0]  max_batches,
  input  logic [31:0]       target,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [31:0]       win_nonce,
  output logic [31:0]       win_hash,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  batches_run,
  output logic              core_start,
  output logic [31:0]       core_nonce_base,
  output logic [ADDR_W-1:0] core_message_addr,
  input  logic              core_done,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  input  logic [31:0]       mem_read_data
);

  // Read counter spans 0..NUM_NONCES: one extra cycle for the read latency.
  localparam int LANE_W = $clog2(NUM_NONCES);
  localparam int RD_W   = LANE_W + 1;

  sweep_state_e      state;
  logic [ADDR_W-1:0] out_addr_reg;
  logic [ADDR_W-1:0] msg_addr_reg;
  logic [CNT_W-1:0]  max_batches_reg;
  logic [CNT_W-1:0]  batches_run_reg;
  logic [31:0]       target_reg;
  logic [31:0]       base_reg;
  logic [RD_W-1:0]   rd_cnt;
  logic [RD_W-1:0]   lane_off;
  logic              accept;
  logic              last_batch;
  logic              exit_now;
  logic              sample_valid;
  logic [31:0]       lane_nonce;

  assign accept     = (state == ST_IDLE) && start && !abort;
  assign last_batch = (batches_run_reg + CNT_W'(1)) == max_batches_reg;

`ifdef NONCE_SWEEP_EARLY_EXIT_EN
  assign exit_now = last_batch || found;
`else
  assign exit_now = last_batch;
`endif

  // Data for address rd_cnt-1 is on the bus while rd_cnt is 1..NUM_NONCES.
  assign lane_off     = rd_cnt - RD_W'(1);
  assign sample_valid = (state == ST_READ) && (rd_cnt != '0) && !abort;
  assign lane_nonce   = base_reg + 32'(lane_off);

  assign busy              = (state != ST_IDLE) && (state != ST_DONE);
  assign done              = (state == ST_DONE);
  assign core_start        = (state == ST_LAUNCH) && !abort;
  assign core_nonce_base   = base_reg;
  assign core_message_addr = msg_addr_reg;
  assign batches_run       = batches_run_reg;
  assign mem_sel           = (state == ST_READ);
  assign mem_addr          = (state == ST_READ) ? out_addr_reg + ADDR_W'(rd_cnt) : '0;
  assign mem_we            = 1'b0;

  // Sweep sequencing: batch launch, core wait, result read-back and abort handling.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      out_addr_reg    <= '0;
      msg_addr_reg    <= '0;
      max_batches_reg <= '0;
      batches_run_reg <= '0;
      target_reg      <= '0;
      base_reg        <= '0;
      rd_cnt          <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            out_addr_reg    <= output_addr;
            msg_addr_reg    <= message_addr;
            max_batches_reg <= max_batches;
            target_reg      <= target;
            base_reg        <= nonce_start;
            batches_run_reg <= '0;
            rd_cnt          <= '0;
            state           <= (max_batches == '0) ? ST_DONE : ST_LAUNCH;
          end
        end
        ST_LAUNCH: state <= abort ? ST_IDLE : ST_WAIT;
        ST_WAIT: begin
          if (core_done) begin
            // A run that completes in the abort cycle needs no draining.
            state  <= abort ? ST_IDLE : ST_READ;
            rd_cnt <= '0;
          end else if (abort) begin
            state <= ST_DRAIN;
          end
        end
        ST_READ: begin
          if (abort) begin
            state <= ST_IDLE;
          end else if (rd_cnt == RD_W'(NUM_NONCES)) begin
            state <= ST_NEXT;
          end else begin
            rd_cnt <= rd_cnt + RD_W'(1);
          end
        end
        ST_NEXT: begin
          if (abort) begin
            state <= ST_IDLE;
          end else begin
            batches_run_reg <= batches_run_reg + CNT_W'(1);
            if (exit_now) begin
              state <= ST_DONE;
            end else begin
              base_reg <= base_reg + 32'(NUM_NONCES);
              state    <= ST_LAUNCH;
            end
          end
        end
        ST_DRAIN: if (core_done) state <= ST_IDLE;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  nonce_hit_tracker #(
    .CNT_W(CNT_W)
  ) u_tracker (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear        (accept),
    .sample_valid (sample_valid),
    .lane_nonce   (lane_nonce),
    .data         (mem_read_data),
    .target       (target_reg),
    .found        (found),
    .win_nonce    (win_nonce),
    .win_hash     (win_hash),
    .hit_count    (hit_count)
  );

endmodule

// File: doc/nonce_sweep_ctrl.md
# nonce_sweep_ctrl

Scheduler that sweeps a nonce range over the 16-nonce bitcoin hash core. It launches one core run per batch of NUM_NONCES nonces and, after each run, takes over the shared memory port to read back the per-nonce H0 results. Each result is compared against a difficulty target, and the block reports the winning nonce, its hash word and a hit count. It sits between the top-level host registers and the hash core/memory mux.

## Interface
- NUM_NONCES, 16, nonces per core run (power of two)
- ADDR_W, 16, memory address width
- CNT_W, 16, width of batch and hit counters
- clk  in  1  clock (also the memory clock)
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; honoured in IDLE only
- abort  in  1  cancel sweep
- message_addr  in  ADDR_W  forwarded unchanged to core
- output_addr  in  ADDR_W  core result base; controller reads from here
- nonce_start  in  32  first nonce of the sweep
- max_batches  in  CNT_W  number of core runs
- target  in  32  hit when H0 < target (unsigned, strict)
- busy  out  1  high from accepted start until DONE or abort return
- done  out  1  one-cycle pulse at sweep completion
- found  out  1  at least one hit this sweep
- win_nonce  out  32  nonce of first hit
- win_hash  out  32  H0 of first hit
- hit_count  out  CNT_W  total hits, saturating
- batches_run  out  CNT_W  completed core runs
- core_start  out  1  one-cycle launch pulse to core
- core_nonce_base  out  32  nonce of lane 0 for current run
- core_done  in  1  one-cycle completion pulse from core
- mem_sel  out  1  1 = controller owns memory port
- mem_addr  out  ADDR_W  read address (valid while mem_sel)
- mem_we  out  1  constant 0
- mem_read_data  in  32  memory read data

## Operation
- States: IDLE, LAUNCH, WAIT, READ, NEXT, DRAIN, DONE.
- IDLE + start (abort low):
  - latch all inputs;
  - clear found, win_*, hit_count, batches_run;
  - batch index b=0;
  - if max_batches==0, go to DONE with found=0 and no launch; else go to LAUNCH.
- LAUNCH: core_start=1 for exactly one cycle; core_nonce_base = nonce_start + b*NUM_NONCES (mod 2^32); → WAIT.
- WAIT: hold core_nonce_base; on core_done → READ.
- READ:
  - mem_sel=1; mem_addr = output_addr + i for i = 0..NUM_NONCES-1, one per cycle.
  - Each data word is compared when it arrives.
  - Lane i nonce = core_nonce_base + i.
  - On the first hit of the sweep: found=1 and win_nonce/win_hash are captured. Within a batch the lowest lane wins.
  - Every hit increments hit_count, saturating at all-ones.
- NEXT: batches_run++, b++. Go to DONE if b==max_batches, or if early exit applies (see Configuration); otherwise → LAUNCH.
- DONE: done=1 for one cycle, busy falls; → IDLE. Results hold until the next accepted start.
- Abort:
  - In LAUNCH, READ or NEXT: → IDLE next cycle; mem_sel drops, no done pulse.
  - In WAIT: → DRAIN, which waits for core_done and then → IDLE. A core run is never orphaned.
- start while busy: ignored. start and abort together in IDLE: abort wins, start ignored.

## Timing
- Reset values: every output 0, state IDLE, including mem_we=0, mem_sel=0, core_nonce_base=0.
- Memory read latency is one cycle: data for mem_addr presented in cycle c is sampled at the end of cycle c+1.
- READ therefore lasts NUM_NONCES+1 cycles.
- Per-batch overhead: 1 (LAUNCH) + NUM_NONCES+1 (READ) + 1 (NEXT) cycles, plus core latency.
- done asserts the cycle after NEXT of the final batch.
- With max_batches==0, done asserts 2 cycles after start (IDLE→DONE→IDLE).
- Nonce arithmetic wraps at 2^32. Lane index and address offsets are zero-extended.
- core_done outside WAIT/DRAIN is ignored.
- Reset mid-sweep: asynchronous return to IDLE and reset values, no done.

## Configuration
- NONCE_SWEEP_EARLY_EXIT_EN defined: NEXT goes to DONE after the batch in which found first becomes 1. Remaining batches are skipped, and hit_count covers completed batches only.
- Undefined: all max_batches batches always run. hit_count covers the whole range, and win_* still reflect the first hit.

## Structure
- Shared package bitcoin_pkg holds:
  - the state enum type;
  - the NUM_NONCES default;
  - the SHA-256 IV and K constants already used by the core, so both blocks import one source.
- One sub-module: nonce_hit_tracker. It takes sample-valid, lane nonce, data and target. It keeps found, win_nonce, win_hash and saturating hit_count, and has a synchronous clear.

## Test plan
- nonce_start=0x100, max_batches=2, target=0 → no hits; done pulses, found=0, hit_count=0, batches_run=2; core_nonce_base seen as 0x100 then 0x110.
- Batch 0 result at lane 5 = 0x00001234, target=0x00010000, rest 0xFFFFFFFF → found=1, win_nonce=nonce_start+5, win_hash=0x00001234, hit_count=1.
- Hits at lanes 3 and 9 of batch 0 and lane 0 of batch 1, max_batches=3:
  - macro defined → win lane 3, hit_count=2, batches_run=1;
  - macro undefined → hit_count=3, batches_run=3.
- nonce_start=0xFFFFFFF8, max_batches=2 → second core_nonce_base=0x00000008; a hit at lane 9 of batch 0 reports win_nonce=0x00000001.
- abort during WAIT → DRAIN holds until core_done, then IDLE, no done pulse. abort during READ → mem_sel low next cycle.
- max_batches=0 → done 2 cycles after start, core_start never asserted. start with abort high in IDLE → ignored, busy stays 0.
